// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Definitions shared by the semaforo traffic-light controller
//               and its passive monitor. These are the vehicle light codes,
//               the controller phase codes, the monitor FSM state codes and
//               a packed view of the light bus.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

  // Vehicle light encodings (code 3 is invalid on the bus)
  localparam logic [1:0] LIGHT_GREEN  = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_RED    = 2'd2;

  // Controller phases, rotating S0 -> S1 -> S2 -> S3 -> S0
  localparam logic [1:0] PH_S0 = 2'd0;
  localparam logic [1:0] PH_S1 = 2'd1;
  localparam logic [1:0] PH_S2 = 2'd2;
  localparam logic [1:0] PH_S3 = 2'd3;

  // Monitor FSM states
  localparam logic [1:0] MON_UNLOCKED = 2'd0;
  localparam logic [1:0] MON_SYNC     = 2'd1;
  localparam logic [1:0] MON_LOCKED   = 2'd2;

  // Light bus as seen on the wires, in {c1, c2, p1, p2} order
  typedef struct packed {
    logic [1:0] c1;
    logic [1:0] c2;
    logic       p1;
    logic       p2;
  } lights_t;

  // Successor in the rotation; wraps S3 -> S0 through 2-bit overflow
  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_decode.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_decode
// Description : Combinational decoder. It maps the traffic-light bus back to
//               a controller phase and flags combinations that no phase
//               produces.
// Ports       : c1, c2 (in, 2b)  vehicle lights
//               p1, p2 (in, 1b)  pedestrian lights
//               phase  (out, 2b) decoded phase (S0 when illegal)
//               legal  (out, 1b) bus matches one of the four phases
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_decode
  import semaforo_pkg::*;
(
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic       p1,
  input  logic       p2,
  output logic [1:0] phase,
  output logic       legal
);

  lights_t bus;
  assign bus = {c1, c2, p1, p2};

  always_comb begin
    phase = PH_S0;
    legal = 1'b0;
    case (bus)
      {LIGHT_GREEN,  LIGHT_RED,    1'b1, 1'b0}: begin phase = PH_S0; legal = 1'b1; end
      {LIGHT_YELLOW, LIGHT_RED,    1'b1, 1'b0}: begin phase = PH_S1; legal = 1'b1; end
      {LIGHT_RED,    LIGHT_GREEN,  1'b0, 1'b1}: begin phase = PH_S2; legal = 1'b1; end
      {LIGHT_RED,    LIGHT_YELLOW, 1'b0, 1'b1}: begin phase = PH_S3; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_monitor
// Description : Passive checker on the semaforo light bus. It decodes the
//               bus into a phase, locks onto the S0..S3 rotation, checks
//               each phase dwell against the configured green and yellow
//               durations, and counts completed rotations.
// Ports       : clk          (in)      system clock, rising edge
//               rst          (in)      asynchronous reset, active high
//               c1, c2       (in, 2b)  vehicle lights
//               p1, p2       (in, 1b)  pedestrian lights
//               phase        (out, 2b) last legal decoded phase
//               phase_valid  (out)     last sample was legal
//               locked       (out)     monitor is locked on the rotation
//               err_illegal  (out)     sticky: illegal combination seen
//               err_seq      (out)     sticky: out-of-order transition seen
//               err_time     (out)     sticky: dwell-time violation seen
//               cycle_cnt    (out, 8b) completed rotations, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 4,   // S0/S2 dwell, 1..14
  parameter int unsigned YELLOW_CYC = 2    // S1/S3 dwell, 1..14
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic       p1,
  input  logic       p2,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic       err_illegal,
  output logic       err_seq,
  output logic       err_time,
  output logic [7:0] cycle_cnt
);

  localparam logic [3:0] GREEN_DW  = 4'(GREEN_CYC);
  localparam logic [3:0] YELLOW_DW = 4'(YELLOW_CYC);
  localparam logic [3:0] DWELL_MAX = 4'd15;

  logic [1:0] dec_phase;
  logic       dec_legal;

  logic [1:0] state;
  logic [1:0] prev;
  logic [3:0] dwell;

  logic [3:0] exp_dwell;
  logic [3:0] dwell_inc;
  logic       is_same;
  logic       is_succ;

  semaforo_decode u_decode (
    .c1    (c1),
    .c2    (c2),
    .p1    (p1),
    .p2    (p2),
    .phase (dec_phase),
    .legal (dec_legal)
  );

  // Even phases (S0, S2) are the green ones
  assign exp_dwell = prev[0] ? YELLOW_DW : GREEN_DW;
  // Saturate so a long overstay cannot wrap and re-arm the overstay match
  assign dwell_inc = (dwell == DWELL_MAX) ? DWELL_MAX : dwell + 4'd1;
  assign is_same   = (dec_phase == prev);
  assign is_succ   = (dec_phase == next_phase(prev));
  assign locked    = (state == MON_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MON_UNLOCKED;
      prev        <= PH_S0;
      dwell       <= 4'd0;
      phase       <= PH_S0;
      phase_valid <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_time    <= 1'b0;
      cycle_cnt   <= 8'd0;
    end else if (!dec_legal) begin
      // Illegal bus beats every other check; phase keeps its last legal value
      err_illegal <= 1'b1;
      phase_valid <= 1'b0;
      state       <= MON_UNLOCKED;
    end else begin
      phase       <= dec_phase;
      phase_valid <= 1'b1;
      case (state)
        MON_UNLOCKED: begin
          state <= MON_SYNC;
          prev  <= dec_phase;
          dwell <= 4'd1;
        end
        MON_SYNC: begin
          // The first dwell after sync is partial, so no time check here
          if (is_same) begin
            dwell <= dwell_inc;
          end else begin
            if (is_succ) begin
              state <= MON_LOCKED;
            end else begin
              err_seq <= 1'b1;
            end
            prev  <= dec_phase;
            dwell <= 4'd1;
          end
        end
        MON_LOCKED: begin
          if (is_same) begin
            dwell <= dwell_inc;
            // Flag the overstay on the exact cycle it happens
            if (dwell_inc == exp_dwell + 4'd1) begin
              err_time <= 1'b1;
            end
          end else if (is_succ) begin
            if (dwell < exp_dwell) begin
              err_time <= 1'b1;
            end
            if (prev == PH_S3) begin
              cycle_cnt <= cycle_cnt + 8'd1;
            end
            prev  <= dec_phase;
            dwell <= 4'd1;
          end else begin
            err_seq <= 1'b1;
            state   <= MON_SYNC;
            prev    <= dec_phase;
            dwell   <= 4'd1;
          end
        end
        default: begin
          state <= MON_UNLOCKED;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_monitor
// Description : Self-checking bench for semaforo_monitor. It runs a table of
//               hand-derived vectors, a few hand-written sequences, a
//               controller-timed run, and random traffic checked against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_monitor;

  localparam int G = 4;
  localparam int Y = 2;

  logic       clk;
  logic       rst;
  logic [1:0] c1, c2;
  logic       p1, p2;
  logic [1:0] phase;
  logic       phase_valid, locked, err_illegal, err_seq, err_time;
  logic [7:0] cycle_cnt;

  int vectors;
  int miscompares;

  semaforo_monitor #(.GREEN_CYC(G), .YELLOW_CYC(Y)) dut (
    .clk         (clk),
    .rst         (rst),
    .c1          (c1),
    .c2          (c2),
    .p1          (p1),
    .p2          (p2),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_time    (err_time),
    .cycle_cnt   (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- light patterns straight from the phase table ----------
  // code 0..3 = S0..S3, code 4 = the illegal {0,0,1,1}
  function automatic logic [5:0] pattern(input int code);
    case (code)
      0: return {2'd0, 2'd2, 1'b1, 1'b0};
      1: return {2'd1, 2'd2, 1'b1, 1'b0};
      2: return {2'd2, 2'd0, 1'b0, 1'b1};
      3: return {2'd2, 2'd1, 1'b0, 1'b1};
      default: return {2'd0, 2'd0, 1'b1, 1'b1};
    endcase
  endfunction

  // Returns the phase a raw bus value stands for, or -1 when illegal
  function automatic int tb_decode(input logic [5:0] bus);
    for (int k = 0; k < 4; k++) begin
      if (pattern(k) == bus) return k;
    end
    return -1;
  endfunction

  // ---------------- behavioural reference model ---------------------------
  int m_mode;   // 0 = not synced, 1 = synced but unverified, 2 = locked
  int m_last;   // phase currently dwelling in
  int m_run;    // samples spent in m_last, capped at 15
  int m_phase;
  bit m_valid, m_ill, m_seq, m_time;
  int m_cnt;

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_run = 0; m_phase = 0;
    m_valid = 0; m_ill = 0; m_seq = 0; m_time = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int ph);
    int delta;
    int need;
    if (ph < 0) begin
      m_ill = 1; m_valid = 0; m_mode = 0;
      return;
    end
    m_phase = ph;
    m_valid = 1;
    delta   = (ph - m_last + 4) % 4;
    need    = (m_last % 2 == 0) ? G : Y;
    if (m_mode == 0) begin
      m_mode = 1; m_last = ph; m_run = 1;
    end else if (delta == 0) begin
      m_run = (m_run + 1 > 15) ? 15 : m_run + 1;
      if (m_mode == 2 && m_run == need + 1) m_time = 1;
    end else if (delta == 1) begin
      if (m_mode == 2) begin
        if (m_run < need) m_time = 1;
        if (m_last == 3) m_cnt = (m_cnt + 1) % 256;
      end
      m_mode = 2; m_last = ph; m_run = 1;
    end else begin
      m_seq = 1; m_mode = 1; m_last = ph; m_run = 1;
    end
  endtask

  // ---------------- comparison ---------------------------------------------
  task automatic check(input string name, input logic [1:0] e_ph, input bit e_v,
                       input bit e_l, input bit e_il, input bit e_sq, input bit e_tm,
                       input int e_cnt);
    vectors++;
    if (phase !== e_ph || phase_valid !== e_v || locked !== e_l ||
        err_illegal !== e_il || err_seq !== e_sq || err_time !== e_tm ||
        cycle_cnt !== 8'(e_cnt)) begin
      miscompares++;
      $display("FAIL %s @%0t: got ph=%0d v=%0b lk=%0b ill=%0b seq=%0b tm=%0b cnt=%0d, want ph=%0d v=%0b lk=%0b ill=%0b seq=%0b tm=%0b cnt=%0d",
               name, $time, phase, phase_valid, locked, err_illegal, err_seq, err_time,
               cycle_cnt, e_ph, e_v, e_l, e_il, e_sq, e_tm, e_cnt);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 2'(m_phase), m_valid, m_mode == 2, m_ill, m_seq, m_time, m_cnt);
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive a raw bus, let one edge sample it, then advance the model and check
  task automatic step_raw(input logic [5:0] bus, input string name);
    {c1, c2, p1, p2} = bus;
    @(posedge clk);
    #1;
    model_step(tb_decode(bus));
    check_model(name);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit rst_before;
    int code;
    int ph;
    bit v, l, il, sq, tm;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input int code, input int ph, input bit v,
                              input bit l, input bit il, input bit sq, input bit tm,
                              input int cnt);
    vec_t e;
    e.rst_before = r; e.code = code; e.ph = ph; e.v = v; e.l = l;
    e.il = il; e.sq = sq; e.tm = tm; e.cnt = cnt;
    tbl.push_back(e);
  endfunction

  // Native controller timing: S0 x4, S1 x2, S2 x4, S3 x2
  function automatic int ctrl_code(input int k);
    int m;
    m = k % 12;
    if (m < 4)  return 0;
    if (m < 6)  return 1;
    if (m < 10) return 2;
    return 3;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    {c1, c2, p1, p2} = pattern(0);
    model_reset();

    // --- three clean rotations, lock from first S0->S1, then overstay S0 ---
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) add(r == 0 && i == 0, 0, 0, 1, r > 0, 0, 0, 0, r);
      for (int i = 0; i < 2; i++) add(0, 1, 1, 1, 1, 0, 0, 0, r);
      for (int i = 0; i < 4; i++) add(0, 2, 2, 1, 1, 0, 0, 0, r);
      for (int i = 0; i < 2; i++) add(0, 3, 3, 1, 1, 0, 0, 0, r);
    end
    add(0, 0, 0, 1, 1, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 0, 0, 0, 3);
    add(0, 0, 0, 1, 1, 0, 0, 1, 3);        // 5th S0 sample overstays
    // --- short yellow, then illegal bus, then re-lock ---
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 2, 2, 1, 1, 0, 0, 1, 0);        // S1 held 1 cycle only
    add(0, 4, 2, 0, 0, 1, 0, 1, 0);        // illegal: phase holds, unlock
    add(0, 3, 3, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0, 1, 0);        // relock without counting
    // --- skip while locked, then recover ---
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 2, 2, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 3, 3, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 2, 2, 1, 0, 0, 1, 0, 1);        // S0 -> S2 skip
    add(0, 3, 3, 1, 1, 0, 1, 0, 1);

    reset_dut();
    check("reset", 2'd0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) reset_dut();
      {c1, c2, p1, p2} = pattern(tbl[i].code);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), 2'(tbl[i].ph), tbl[i].v, tbl[i].l,
            tbl[i].il, tbl[i].sq, tbl[i].tm, tbl[i].cnt);
    end

    // --- build up every error flag, then async reset mid-S2 ---
    reset_dut();
    step_raw(pattern(0), "allerr_s0");
    step_raw(pattern(1), "allerr_s1");
    step_raw(pattern(2), "allerr_short");
    step_raw(pattern(4), "allerr_illegal");
    step_raw(pattern(1), "allerr_resync");
    step_raw(pattern(3), "allerr_seq");
    step_raw(pattern(0), "allerr_lock");
    step_raw(pattern(1), "allerr_s1b");
    step_raw(pattern(2), "allerr_s2");
    check("allerr_flags", 2'd2, 1, 1, 1, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 2'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // --- controller-timed traffic for 100 cycles ---
    for (int k = 0; k < 100; k++) step_raw(pattern(ctrl_code(k)), "ctrl");
    check("ctrl_final", 2'd0, 1, 1, 0, 0, 0, 8);

    // --- random traffic against the model ---
    reset_dut();
    begin
      int gen;
      int rem;
      int r;
      gen = 0;
      rem = G;
      for (int n = 0; n < 3000; n++) begin
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          step_raw(6'($urandom), "rand_raw");
        end else if (r < 5) begin
          gen = int'($urandom_range(0, 3));
          rem = int'($urandom_range(0, 5));
          step_raw(pattern(gen), "rand_jump");
        end else begin
          if (rem <= 0) begin
            gen = (gen + 1) % 4;
            rem = ((gen % 2 == 0) ? G : Y);
            if ($urandom_range(0, 9) == 0) rem = rem + int'($urandom_range(0, 2)) - 1;
          end
          rem--;
          step_raw(pattern(gen), "rand_rot");
        end
        if ($urandom_range(0, 499) == 0) reset_dut();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/semaforo_monitor.md
# semaforo_monitor

Passive checker sitting on the traffic-light output bus of the `semaforo` controller (vehicle lights `c1`/`c2`, pedestrian lights `p1`/`p2`). It decodes the four signals back into a controller phase and tracks the rotation S0→S1→S2→S3→S0. It checks every phase dwell against the configured green and yellow durations, and reports sticky error flags plus a count of completed rotations. It is the consuming end of the light interface: used in system simulation and as an on-board safety monitor.

## Interface
- `GREEN_CYC`, default 4: required dwell in cycles of phases S0 and S2; legal range 1..14.
- `YELLOW_CYC`, default 2: required dwell in cycles of phases S1 and S3; legal range 1..14.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `c1`, `c2`  in  2 each  vehicle lights; 0 = green, 1 = yellow, 2 = red, 3 = invalid.
- `p1`, `p2`  in  1 each  pedestrian lights.
- `phase`  out  2  last decoded legal phase (0..3).
- `phase_valid`  out  1  last sample was a legal combination.
- `locked`  out  1  monitor is in LOCKED.
- `err_illegal`  out  1  sticky; an illegal light combination was seen.
- `err_seq`  out  1  sticky; a phase transition out of order was seen.
- `err_time`  out  1  sticky; a dwell-time violation was seen.
- `cycle_cnt`  out  8  completed rotations (S3→S0 transitions while LOCKED); wraps 255→0.

## Operation
- Legal combinations as {c1, c2, p1, p2}:
  - S0 = {0, 2, 1, 0}
  - S1 = {1, 2, 1, 0}
  - S2 = {2, 0, 0, 1}
  - S3 = {2, 1, 0, 1}
- Any other combination is illegal.
- Successor of Sn is S(n+1 mod 4).
- Expected dwell: `GREEN_CYC` for S0 and S2; `YELLOW_CYC` for S1 and S3.
- Internal state: `prev` (2 b), `dwell` (4 b, saturates at 15), FSM {UNLOCKED, SYNC, LOCKED}.
- On every edge, the inputs are sampled, then:
  - Illegal sample, any state: `err_illegal` <= 1, go to UNLOCKED, `phase_valid` <= 0, `phase` holds its old value.
  - UNLOCKED, legal sample: go to SYNC, `prev` <= phase, `dwell` <= 1.
  - SYNC, same phase: `dwell`++. No time check; the first dwell after sync is partial.
  - SYNC, successor phase: go to LOCKED, `dwell` <= 1.
  - SYNC, non-successor phase: `err_seq` <= 1, stay in SYNC, `prev` <= new phase, `dwell` <= 1.
  - LOCKED, same phase: `dwell`++. If the new value equals expected+1, `err_time` <= 1 (overstay is flagged the moment it occurs).
  - LOCKED, successor phase: if `dwell` < expected, `err_time` <= 1. Then `dwell` <= 1. If the transition is S3→S0, `cycle_cnt`++.
  - LOCKED, non-successor phase (including a skip or a reverse step): `err_seq` <= 1, go to SYNC, `dwell` <= 1.
- Error flags are cleared only by `rst`. They never affect FSM progress.
- Several errors in the same cycle are not possible, because illegal samples take priority.

## Timing
- Reset values: `phase` = 0, `phase_valid` = 0, `locked` = 0, all `err_*` = 0, `cycle_cnt` = 0.
- FSM and counters reset to UNLOCKED / 0.
- All outputs are registered. The response to an input sampled at edge N is visible after edge N.
- Reset asserted mid-rotation clears everything immediately (asynchronously). After release, the monitor resynchronises on the next sample.
- With the controller's native timing (GREEN_CYC = 4, YELLOW_CYC = 2) the rotation period is 12 cycles.
- `dwell` saturation at 15 keeps an overstayed phase from wrapping and re-arming the overstay check.

## Structure
- Shared package `semaforo_pkg` holds:
  - light encodings (`LIGHT_GREEN` = 0, `LIGHT_YELLOW` = 1, `LIGHT_RED` = 2);
  - phase encodings S0..S3;
  - monitor FSM state encodings.
- The `semaforo` controller also uses this package.
- One sub-module: `semaforo_decode`, combinational. It maps {c1, c2, p1, p2} to {phase, legal}.

## Test plan
- Reset, then drive S0×4, S1×2, S2×4, S3×2 three times followed by S0 → `locked` = 1 from the first S0→S1 onward; no errors; `cycle_cnt` = 3.
- After locking, hold S0 for 5 cycles → `err_time` = 1 after the 5th S0 sample; `locked` stays 1.
- After locking, drive S1 for 1 cycle then S2 → `err_time` = 1 after the S2 sample; `err_seq` = 0.
- Drive {0, 0, 1, 1} for one cycle while LOCKED → `err_illegal` = 1, `phase_valid` = 0, `locked` = 0. A following legal rotation re-locks, and `err_illegal` stays 1.
- While LOCKED, drive S0×4 then S2 → `err_seq` = 1, `locked` = 0. The next S3 gives `locked` = 1.
- Assert `rst` mid-S2 with all error flags set → all outputs read 0 before the next clock edge.
- Instantiate the `semaforo` controller driving the monitor for 100 cycles → all `err_*` = 0 and `cycle_cnt` = 8.
